// File: rtl/algo_mbnk_freelist_alloc.sv
// ---------------------------------------------------------------------------
// algo_mbnk_freelist_alloc
//   Multi-bank free-address allocator. Each virtual bank owns a free-row FIFO
//   that is filled with rows 0..NUMVROW-1 after reset. Malloc ports pop rows
//   from the FIFOs. Dequeue ports push returned rows back. Per-bank status
//   covers free count, empty and backpressure (threshold plus hysteresis).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   ready               initialisation finished, allocator serving requests
//   ma_write/ma_bnk     per-port malloc request and target bank
//   ma_vld/ma_adr       grant and granted {bank,row}, one cycle after request
//   ma_bp               request refused (lost arbitration, empty, not ready)
//   dq_vld/dq_adr       per-port address return {bank,row}
//   bp_thr/bp_hys       backpressure assert level and hysteresis
//   grpbp/grpmt/grpcnt  per-bank backpressure, empty flag, free count
//   dq_err              sticky protocol error (bad or conflicting return)
// ---------------------------------------------------------------------------
module algo_mbnk_freelist_alloc #(
  parameter int NUMMAPT = 4,
  parameter int NUMDQPT = 4,
  parameter int NUMVBNK = 8,
  parameter int BITVBNK = 3,
  parameter int NUMVROW = 64,
  parameter int BITVROW = 6,
  parameter int BITADDR = BITVBNK + BITVROW
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ready,
  input  logic [NUMMAPT-1:0]             ma_write,
  input  logic [NUMMAPT*BITVBNK-1:0]     ma_bnk,
  output logic [NUMMAPT-1:0]             ma_vld,
  output logic [NUMMAPT*BITADDR-1:0]     ma_adr,
  output logic [NUMMAPT-1:0]             ma_bp,
  input  logic [NUMDQPT-1:0]             dq_vld,
  input  logic [NUMDQPT*BITADDR-1:0]     dq_adr,
  input  logic [BITVROW:0]               bp_thr,
  input  logic [BITVROW:0]               bp_hys,
  output logic [NUMVBNK-1:0]             grpbp,
  output logic [NUMVBNK-1:0]             grpmt,
  output logic [NUMVBNK*(BITVROW+1)-1:0] grpcnt,
  output logic                           dq_err
);

  localparam int CW = BITVROW + 1;

  typedef enum logic [1:0] {INIT, DONE, RUN} state_t;

  state_t                          state_reg;
  logic [BITVROW-1:0]              init_row_reg;
  logic                            ready_reg;
  logic [NUMMAPT-1:0]              ma_vld_reg;
  logic [NUMMAPT-1:0]              ma_bp_reg;
  logic [NUMMAPT*BITADDR-1:0]      ma_adr_reg;
  logic [NUMMAPT*BITADDR-1:0]      ma_adr_next;
  logic                            dq_err_reg;

  logic [NUMVBNK-1:0][CW-1:0]      cnt_all;
  logic [NUMVBNK-1:0][BITVROW-1:0] head_all;
  logic [NUMMAPT-1:0]              grant;
  logic [NUMVBNK-1:0]              pop;
  logic [NUMVBNK-1:0]              push;
  logic [NUMVBNK-1:0][BITVROW-1:0] push_row;
  logic                            err_next;

  // Malloc arbitration. Ports are scanned in ascending order, so the first
  // port to claim a bank (pop set) is the lowest-index requester. The empty
  // check uses the pre-update count, so a same-cycle return never feeds a malloc.
  always_comb begin : arb
    logic [BITVBNK-1:0] b;
    b           = '0;
    grant       = '0;
    pop         = '0;
    ma_adr_next = '0;
    for (int p = 0; p < NUMMAPT; p++) begin
      b = ma_bnk[p*BITVBNK +: BITVBNK];
      if (ma_write[p] && ready_reg && !pop[b] && (cnt_all[b] != '0)) begin
        grant[p]                        = 1'b1;
        pop[b]                          = 1'b1;
        ma_adr_next[p*BITADDR +: BITADDR] = {b, head_all[b]};
      end
    end
  end

  // Address returns. The lowest port wins per bank. Duplicates, returns to a
  // full bank and any return before ready are dropped and flagged.
  always_comb begin : ret
    logic [BITVBNK-1:0] qb;
    qb       = '0;
    push     = '0;
    push_row = '0;
    err_next = 1'b0;
    for (int q = 0; q < NUMDQPT; q++) begin
      qb = dq_adr[q*BITADDR + BITVROW +: BITVBNK];
      if (dq_vld[q]) begin
        if (!ready_reg || push[qb] || (cnt_all[qb] == CW'(NUMVROW))) begin
          err_next = 1'b1;
        end else begin
          push[qb]     = 1'b1;
          push_row[qb] = dq_adr[q*BITADDR +: BITVROW];
        end
      end
    end
  end

  // Control FSM and per-port response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= INIT;
      init_row_reg <= '0;
      ready_reg    <= 1'b0;
      ma_vld_reg   <= '0;
      ma_bp_reg    <= '0;
      ma_adr_reg   <= '0;
      dq_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        INIT: begin
          init_row_reg <= init_row_reg + BITVROW'(1);
          if (init_row_reg == BITVROW'(NUMVROW - 1)) state_reg <= DONE;
        end
        DONE:    state_reg <= RUN;
        RUN:     ready_reg <= 1'b1;
        default: state_reg <= INIT;
      endcase
      ma_vld_reg <= grant;
      ma_bp_reg  <= ma_write & ~grant;
      ma_adr_reg <= ma_adr_next;
      if (err_next) dq_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUMVBNK; gi++) begin : g_bank
      logic [BITVROW-1:0] mem [NUMVROW];
      logic [BITVROW-1:0] rd_ptr_reg;
      logic [BITVROW-1:0] wr_ptr_reg;
      logic [CW-1:0]      cnt_reg;
      logic [CW-1:0]      cnt_next;
      logic               mt_reg;
      logic               bp_reg;
      logic [CW:0]        clr_lvl;

      // During INIT every bank is loaded with its identity row list. After
      // that, only accepted returns write, at the tail pointer.
      always_ff @(posedge clk) begin
        if (state_reg == INIT) mem[init_row_reg] <= init_row_reg;
        else if (push[gi])     mem[wr_ptr_reg]   <= push_row[gi];
      end

      assign head_all[gi] = mem[rd_ptr_reg];
      assign cnt_next     = cnt_reg - CW'(pop[gi]) + CW'(push[gi]);
      // The clear level is one bit wider so thr+hys cannot wrap.
      assign clr_lvl      = {1'b0, bp_thr} + {1'b0, bp_hys};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
          cnt_reg    <= '0;
          mt_reg     <= 1'b1;
          bp_reg     <= 1'b0;
        end else if (state_reg == INIT) begin
          // Pointers stay at 0: a full FIFO has rd_ptr == wr_ptr.
          if (init_row_reg == BITVROW'(NUMVROW - 1)) begin
            cnt_reg <= CW'(NUMVROW);
            mt_reg  <= 1'b0;
          end
        end else begin
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + BITVROW'(1);
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + BITVROW'(1);
          cnt_reg <= cnt_next;
          mt_reg  <= (cnt_next == '0);
          if (cnt_next <= bp_thr)               bp_reg <= 1'b1;
          else if ({1'b0, cnt_next} > clr_lvl)  bp_reg <= 1'b0;
        end
      end

      assign cnt_all[gi]           = cnt_reg;
      assign grpcnt[gi*CW +: CW]   = cnt_reg;
      assign grpmt[gi]             = mt_reg;
      assign grpbp[gi]             = bp_reg;
    end
  endgenerate

  assign ready  = ready_reg;
  assign ma_vld = ma_vld_reg;
  assign ma_bp  = ma_bp_reg;
  assign ma_adr = ma_adr_reg;
  assign dq_err = dq_err_reg;

endmodule

// File: tb/tb_algo_mbnk_freelist_alloc.sv
// ---------------------------------------------------------------------------
// tb_algo_mbnk_freelist_alloc
//   Directed bench for the multi-bank free-address allocator. The stimulus
//   pushes hand-computed expected malloc responses into a queue. A monitor
//   pops an entry each time a port shows ma_vld or ma_bp and compares it.
//   Status outputs are checked directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_algo_mbnk_freelist_alloc;
  localparam int NMA = 4, NDQ = 4, NB = 8, BB = 3, NR = 64, BR = 6, BA = 9, CW = 7;

  logic              clk, rst, ready;
  logic [NMA-1:0]    ma_write, ma_vld, ma_bp;
  logic [NMA*BB-1:0] ma_bnk;
  logic [NMA*BA-1:0] ma_adr;
  logic [NDQ-1:0]    dq_vld;
  logic [NDQ*BA-1:0] dq_adr;
  logic [BR:0]       bp_thr, bp_hys;
  logic [NB-1:0]     grpbp, grpmt;
  logic [NB*CW-1:0]  grpcnt;
  logic              dq_err;

  typedef struct {int port; int vld; int adr;} exp_t;
  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  algo_mbnk_freelist_alloc #(
    .NUMMAPT(NMA), .NUMDQPT(NDQ), .NUMVBNK(NB), .BITVBNK(BB),
    .NUMVROW(NR), .BITVROW(BR), .BITADDR(BA)
  ) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .ma_write(ma_write), .ma_bnk(ma_bnk), .ma_vld(ma_vld), .ma_adr(ma_adr), .ma_bp(ma_bp),
    .dq_vld(dq_vld), .dq_adr(dq_adr), .bp_thr(bp_thr), .bp_hys(bp_hys),
    .grpbp(grpbp), .grpmt(grpmt), .grpcnt(grpcnt), .dq_err(dq_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic int cnt_of(input int b);
    return int'(grpcnt[b*CW +: CW]);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    ma_write = '0;
    ma_bnk   = '0;
    dq_vld   = '0;
    dq_adr   = '0;
  endtask

  task automatic mreq(input int p, input int b);
    ma_write[p]          = 1'b1;
    ma_bnk[p*BB +: BB]   = BB'(b);
  endtask

  task automatic dq(input int q, input int b, input int r);
    dq_vld[q]            = 1'b1;
    dq_adr[q*BA +: BA]   = {BB'(b), BR'(r)};
  endtask

  task automatic push_exp(input int p, input int v, input int b, input int r);
    exp_t e;
    e.port = p;
    e.vld  = v;
    e.adr  = (v != 0) ? (b * NR + r) : 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready) begin
        n = i;
        break;
      end
    end
    chk(nm, n, 66);
  endtask

  // Monitor: one queue entry per presented response, ports in ascending order.
  initial begin : monitor
    exp_t e;
    int   act_adr;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NMA; p++) begin
        if (ma_vld[p] || ma_bp[p]) begin
          chk("vld_bp_exclusive", int'(ma_vld[p] & ma_bp[p]), 0);
          act_adr = ma_vld[p] ? int'(ma_adr[p*BA +: BA]) : 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_resp_port", p, -1);
          end else begin
            e = exp_q.pop_front();
            $display("resp port=%0d vld=%0d adr=%0d (exp port=%0d vld=%0d adr=%0d)",
                     p, ma_vld[p], act_adr, e.port, e.vld, e.adr);
            chk("resp_port_vld_adr", p * 1024 + int'(ma_vld[p]) * 512 + act_adr,
                e.port * 1024 + e.vld * 512 + e.adr);
          end
        end
      end
    end
  end

  initial begin : stim
    int ready_at;
    rst    = 1'b1;
    bp_thr = 7'd4;
    bp_hys = 7'd3;
    idle();

    // Reset state.
    step();
    step();
    chk("rst_ready", int'(ready), 0);
    chk("rst_ma_vld", int'(ma_vld), 0);
    chk("rst_ma_bp", int'(ma_bp), 0);
    chk("rst_ma_adr", int'(ma_adr), 0);
    chk("rst_grpmt", int'(grpmt), 255);
    chk("rst_grpcnt", int'(grpcnt != '0), 0);
    chk("rst_grpbp", int'(grpbp), 0);
    chk("rst_dq_err", int'(dq_err), 0);

    // Initialisation: ready at the 66th edge, malloc during init refused.
    rst      = 1'b0;
    ready_at = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (i == 10) begin
        mreq(3, 0);
        push_exp(3, 0, 0, 0);
      end else if (i == 11) begin
        idle();
      end
      if (ready) begin
        ready_at = i;
        break;
      end
    end
    chk("ready_latency", ready_at, 66);
    for (int b = 0; b < NB; b++) chk("init_grpcnt", cnt_of(b), 64);
    chk("init_grpmt", int'(grpmt), 0);
    chk("init_grpbp", int'(grpbp), 0);

    // Two ports on bank 3: port 0 wins row 0, port 2 refused.
    mreq(0, 3);
    mreq(2, 3);
    push_exp(0, 1, 3, 0);
    push_exp(2, 0, 0, 0);
    step();
    idle();
    chk("bank3_cnt_after_grant", cnt_of(3), 63);
    // Same-cycle malloc and return on bank 3: count unchanged.
    mreq(0, 3);
    dq(0, 3, 0);
    push_exp(0, 1, 3, 1);
    step();
    idle();
    chk("bank3_cnt_pop_push", cnt_of(3), 63);

    // Drain bank 5 in order.
    for (int r = 0; r < 64; r++) begin
      mreq(1, 5);
      push_exp(1, 1, 5, r);
      step();
      idle();
    end
    chk("bank5_empty_grpmt", int'(grpmt[5]), 1);
    chk("bank5_empty_cnt", cnt_of(5), 0);
    chk("bank5_empty_grpbp", int'(grpbp[5]), 1);
    // 65th malloc with same-cycle return of row 17: malloc refused, row stored.
    mreq(1, 5);
    dq(0, 5, 17);
    push_exp(1, 0, 0, 0);
    step();
    idle();
    chk("bank5_cnt_after_return", cnt_of(5), 1);
    chk("bank5_grpmt_after_return", int'(grpmt[5]), 0);
    mreq(1, 5);
    push_exp(1, 1, 5, 17);
    step();
    idle();
    chk("bank5_cnt_regrant", cnt_of(5), 0);

    // Backpressure on bank 1: thr=4, hys=3.
    for (int r = 0; r < 60; r++) begin
      if (r == 59) chk("bank1_bp_at_5", int'(grpbp[1]), 0);
      mreq(0, 1);
      push_exp(0, 1, 1, r);
      step();
      idle();
    end
    chk("bank1_cnt_4", cnt_of(1), 4);
    chk("bank1_bp_at_4", int'(grpbp[1]), 1);
    for (int r = 0; r < 3; r++) begin
      dq(1, 1, r);
      step();
      idle();
    end
    chk("bank1_cnt_7", cnt_of(1), 7);
    chk("bank1_bp_at_7", int'(grpbp[1]), 1);
    dq(1, 1, 3);
    step();
    idle();
    chk("bank1_cnt_8", cnt_of(1), 8);
    chk("bank1_bp_at_8", int'(grpbp[1]), 0);

    // Duplicate return to bank 2.
    for (int r = 0; r < 2; r++) begin
      mreq(0, 2);
      push_exp(0, 1, 2, r);
      step();
      idle();
    end
    chk("dq_err_before_dup", int'(dq_err), 0);
    dq(0, 2, 0);
    dq(1, 2, 1);
    step();
    idle();
    chk("bank2_cnt_dup", cnt_of(2), 63);
    chk("dq_err_dup", int'(dq_err), 1);
    step();
    step();
    step();
    chk("dq_err_sticky", int'(dq_err), 1);
    dq(0, 4, 5);
    step();
    idle();
    chk("bank4_full_cnt", cnt_of(4), 64);

    // Reset while a grant is on the outputs.
    mreq(0, 6);
    push_exp(0, 1, 6, 0);
    step();
    idle();
    mreq(0, 6);
    step();
    idle();
    chk("grant_before_rst", int'(ma_vld[0]), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_ma_vld", int'(ma_vld), 0);
    chk("midrst_ma_adr", int'(ma_adr), 0);
    chk("midrst_grpmt", int'(grpmt), 255);
    chk("midrst_grpcnt", int'(grpcnt != '0), 0);
    chk("midrst_grpbp", int'(grpbp), 0);
    chk("midrst_dq_err", int'(dq_err), 0);
    step();
    step();
    rst = 1'b0;
    wait_ready("ready_latency_reinit");
    chk("reinit_grpcnt6", cnt_of(6), 64);
    chk("reinit_dq_err", int'(dq_err), 0);
    // Return to a full bank: dropped and flagged.
    dq(0, 4, 5);
    step();
    idle();
    chk("full_return_dq_err", int'(dq_err), 1);
    chk("full_return_cnt", cnt_of(4), 64);
    // Allocation restarts at row 0.
    mreq(0, 6);
    mreq(1, 3);
    push_exp(0, 1, 6, 0);
    push_exp(1, 1, 3, 0);
    step();
    idle();
    step();

    // Return while not ready.
    #1 rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst3_dq_err", int'(dq_err), 0);
    dq(2, 0, 0);
    step();
    idle();
    chk("notready_ready", int'(ready), 0);
    chk("notready_dq_err", int'(dq_err), 1);

    step();
    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
